// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential 32-bit DIV/DIVU/REM/REMU unit that stalls the pipeline
// Restoring shift-subtract, one quotient bit per cycle; signs are fixed up on entry to DONE.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        pipe_flush,
  output logic        stall,
  output logic        valid,
  output logic [31:0] y,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] res_q, res_d;
  logic [1:0]  op_q, op_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;

  logic        is_signed, a_neg, b_neg, div0, ovf;
  logic [31:0] a_mag, b_mag;
  logic [32:0] r_sh, diff;
  logic [31:0] q_step, r_step, q_fin, r_fin;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[31];
    b_neg     = is_signed & b[31];
    a_mag     = a_neg ? (~a + 32'd1) : a;
    b_mag     = b_neg ? (~b + 32'd1) : b;
    div0      = (b == 32'd0);
    ovf       = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    r_sh   = {rem_q, quo_q[31]};
    diff   = r_sh - {1'b0, dvs_q};
    q_step = {quo_q[30:0], ~diff[32]};
    r_step = diff[32] ? r_sh[31:0] : diff[31:0];
    q_fin  = negq_q ? (~q_step + 32'd1) : q_step;
    r_fin  = negr_q ? (~r_step + 32'd1) : r_step;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      IDLE: begin
        if (start && !pipe_flush) begin
          op_d   = op;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          quo_d  = a_mag;
          dvs_d  = b_mag;
          rem_d  = 32'd0;
          cnt_d  = 6'd0;
          if (div0) begin
            res_d   = op[1] ? a : 32'hFFFF_FFFF;
            state_d = DONE;
          end else if (ovf) begin
            res_d   = op[1] ? 32'd0 : 32'h8000_0000;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        quo_d = q_step;
        rem_d = r_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          res_d   = op_q[1] ? r_fin : q_fin;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (pipe_flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dvs_q   <= 32'd0;
      res_q   <= 32'd0;
      op_q    <= 2'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      op_q    <= op_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  // Reset gates stall directly since a held start would otherwise assert it in IDLE.
  assign stall = !rst && (((state_q == IDLE) && start && !pipe_flush) || (state_q == CALC));
  assign valid = (state_q == DONE);
  assign y     = valid ? res_q : 32'd0;
  assign busy  = (state_q != IDLE);

endmodule
